// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared definitions for the serial-to-parallel lane receiver.
// Holds the character width shared with the transmit-side serializer, the
// comma/idle character, the synchronisation defaults and the FSM encoding.
package serial_to_parallel_rx_pkg;

    // Character width shared with the parallel-to-serial transmit stage.
    localparam int CHAR_W = 8;

    // Alignment and idle character.
    localparam logic [CHAR_W-1:0] DEF_COMMA = 8'hBC;

    // Consecutive aligned commas needed before the link is declared active.
    localparam int DEF_SYNC_COUNT = 4;

    // Consecutive non-comma characters in ACTIVE that mean loss of sync.
    localparam int DEF_LOS_LIMIT = 16;

    // Receiver link state.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } rx_state_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_rx_bit_aligner.sv
// Bit-level front end of the lane receiver: shifts serial bits into a
// character-wide window, tracks the bit position inside the current
// character and flags the byte boundary and a comma in the window.
// The bit counter is held at zero while the controller is hunting, so the
// first bit after a detected comma is bit 0 of the next character.
module serial_to_parallel_rx_bit_aligner
    import serial_to_parallel_rx_pkg::*;
#(
    parameter int                   DATA_SIZE = CHAR_W,
    parameter logic [DATA_SIZE-1:0] COMMA     = DEF_COMMA
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ser_i,
    input  logic                 cnt_clr_i,
    output logic [DATA_SIZE-1:0] sr_next_o,
    output logic                 boundary_o,
    output logic                 comma_o
);

    localparam int             CNT_W    = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_SIZE-1:0] sr_q;
    logic [DATA_SIZE-1:0] sr_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     bit_cnt_d;

    // Window including the bit being sampled at this edge (MSB first).
    always_comb begin
        sr_d = {sr_q[DATA_SIZE-2:0], ser_i};
    end

    // Bit position: cleared while hunting, otherwise wraps every character.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (cnt_clr_i) begin
            bit_cnt_d = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sr_next_o  = sr_d;
    assign boundary_o = (bit_cnt_q == LAST_BIT);
    assign comma_o    = (sr_d == COMMA);

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel lane receiver.
// Hunts for the comma character with a sliding compare, confirms alignment
// over SYNC_COUNT consecutive aligned commas, then delivers every non-comma
// character as a parallel word with a one-cycle valid strobe. Commas in
// ACTIVE are idle fill.
// Optional feature: define SER_RX_LOS_EN to drop back to HUNT (with an Error
// pulse) after LOS_LIMIT consecutive non-comma characters; without it the
// ACTIVE state is left only by reset.
module serial_to_parallel_rx
    import serial_to_parallel_rx_pkg::*;
#(
    parameter int                   DATA_SIZE  = CHAR_W,
    parameter logic [DATA_SIZE-1:0] COMMA      = DEF_COMMA,
    parameter int                   SYNC_COUNT = DEF_SYNC_COUNT,
    parameter int                   LOS_LIMIT  = DEF_LOS_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid_out,
    output logic                 active,
    output logic                 Error
);

    if ((SYNC_COUNT < 2) || (LOS_LIMIT < 1)) begin : g_bad_cfg
        $error("serial_to_parallel_rx: SYNC_COUNT must be >= 2 and LOS_LIMIT >= 1");
    end

    localparam int              CC_W      = cnt_width(SYNC_COUNT);
    localparam logic [CC_W-1:0] CC_ONE    = CC_W'(1);
    localparam logic [CC_W-1:0] CC_LAST   = CC_W'(SYNC_COUNT - 1);

    rx_state_e            state_q;
    logic [CC_W-1:0]      comma_cnt_q;
    logic [DATA_SIZE-1:0] out_q;
    logic                 valid_q;
    logic                 active_q;
    logic                 error_q;

    logic [DATA_SIZE-1:0] sr_next_s;
    logic                 boundary_s;
    logic                 comma_s;
    logic                 hunting_s;

`ifdef SER_RX_LOS_EN
    localparam int              LOS_W    = cnt_width(LOS_LIMIT);
    localparam logic [LOS_W-1:0] LOS_ONE  = LOS_W'(1);
    localparam logic [LOS_W-1:0] LOS_LAST = LOS_W'(LOS_LIMIT - 1);
    logic [LOS_W-1:0]     los_cnt_q;
`endif

    assign hunting_s = (state_q == ST_HUNT);

    serial_to_parallel_rx_bit_aligner #(
        .DATA_SIZE (DATA_SIZE),
        .COMMA     (COMMA)
    ) u_rx_bit_aligner (
        .clk_i      (clk),
        .rst_i      (reset),
        .ser_i      (in),
        .cnt_clr_i  (hunting_s),
        .sr_next_o  (sr_next_s),
        .boundary_o (boundary_s),
        .comma_o    (comma_s)
    );

    // Link FSM with comma/LOS counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            comma_cnt_q <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
`ifdef SER_RX_LOS_EN
            los_cnt_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    active_q <= 1'b0;
                    if (comma_s) begin
                        comma_cnt_q <= CC_ONE;
                        state_q     <= ST_SYNC;
                    end else begin
                        comma_cnt_q <= '0;
                    end
                end
                ST_SYNC: begin
                    if (boundary_s) begin
                        if (comma_s) begin
                            comma_cnt_q <= comma_cnt_q + CC_ONE;
                            if (comma_cnt_q == CC_LAST) begin
                                state_q  <= ST_ACTIVE;
                                active_q <= 1'b1;
`ifdef SER_RX_LOS_EN
                                los_cnt_q <= '0;
`endif
                            end
                        end else begin
                            state_q     <= ST_HUNT;
                            comma_cnt_q <= '0;
                            error_q     <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (boundary_s) begin
                        if (comma_s) begin
`ifdef SER_RX_LOS_EN
                            los_cnt_q <= '0;
`endif
                        end else begin
                            out_q   <= sr_next_s;
                            valid_q <= 1'b1;
`ifdef SER_RX_LOS_EN
                            if (los_cnt_q == LOS_LAST) begin
                                los_cnt_q   <= '0;
                                state_q     <= ST_HUNT;
                                comma_cnt_q <= '0;
                                active_q    <= 1'b0;
                                error_q     <= 1'b1;
                            end else begin
                                los_cnt_q <= los_cnt_q + LOS_ONE;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_q     <= ST_HUNT;
                    comma_cnt_q <= '0;
                    active_q    <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx: a character-level reference
// model turns each bit stream into expected strobes/edges with cycle stamps;
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_serial_to_parallel_rx;

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         SYNC_COUNT = 4;
    localparam int         LOS_LIMIT  = 16;

    typedef struct { int cyc; logic [7:0] d; } vev_t;
    typedef struct { int cyc; bit lvl; } aev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ser_in = 1'b0;
    logic [7:0] out;
    logic       valid_out;
    logic       active;
    logic       Error;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    vev_t vq[$];
    int   eq[$];
    aev_t aq[$];
    bit   stim[$];
    bit   prev_act = 1'b0;
    logic [7:0] exp_out = 8'h00;
    bit   model_act;

    serial_to_parallel_rx dut (
        .clk       (clk),
        .reset     (reset),
        .in        (ser_in),
        .out       (out),
        .valid_out (valid_out),
        .active    (active),
        .Error     (Error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
    endtask

    // Reference model: character framing by index arithmetic on the bit stream.
    task automatic model_run(input int base);
        logic [7:0] w = 8'h00;
        bit hunting = 1'b1;
        bit act = 1'b0;
        int next_end = 0;
        int commas = 0;
        int los = 0;
        for (int i = 0; i < stim.size(); i++) begin
            w = {w[6:0], stim[i]};
            if (hunting) begin
                if (w == COMMA) begin
                    hunting = 1'b0;
                    next_end = i + 8;
                    commas = 1;
                end
            end else if (i == next_end) begin
                next_end = i + 8;
                if (!act) begin
                    if (w == COMMA) begin
                        commas++;
                        if (commas == SYNC_COUNT) begin
                            act = 1'b1;
                            los = 0;
                            aq.push_back('{base + i, 1'b1});
                        end
                    end else begin
                        hunting = 1'b1;
                        commas = 0;
                        eq.push_back(base + i);
                    end
                end else if (w == COMMA) begin
                    los = 0;
                end else begin
                    vq.push_back('{base + i, w});
                    los++;
`ifdef SER_RX_LOS_EN
                    if (los == LOS_LIMIT) begin
                        los = 0;
                        act = 1'b0;
                        hunting = 1'b1;
                        commas = 0;
                        eq.push_back(base + i);
                        aq.push_back('{base + i, 1'b0});
                    end
`endif
                end
            end
        end
        model_act = act;
    endtask

    // Drive the prepared stream from a negedge right after reset release.
    task automatic run_scen();
        int base;
        base = cyc + 1;
        model_run(base);
        for (int i = 0; i < stim.size(); i++) begin
            ser_in = stim[i];
            @(negedge clk);
        end
        #1;
        chk("pending_valid", vq.size(), 0);
        chk("pending_error", eq.size(), 0);
        chk("pending_active", aq.size(), 0);
        vq.delete();
        eq.delete();
        aq.delete();
        stim.delete();
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset(input bit check_prev);
        if (check_prev) chk("active_before_reset", active, model_act);
        reset = 1'b1;
        #1;
        chk("rst_out", out, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_error", Error, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pop expected events whenever the DUT presents one.
    always @(negedge clk) begin
        vev_t v;
        aev_t a;
        int   e;
        if (reset) begin
            prev_act = 1'b0;
            exp_out = 8'h00;
        end else begin
            if (valid_out) begin
                if (vq.size() == 0) begin
                    chk("valid_unexpected", valid_out, 1'b0);
                end else begin
                    v = vq.pop_front();
                    chk("valid_cycle", cyc, v.cyc);
                    chk("valid_data", out, v.d);
                    exp_out = v.d;
                end
            end
            chk("out_hold", out, exp_out);
            if (Error) begin
                if (eq.size() == 0) begin
                    chk("error_unexpected", Error, 1'b0);
                end else begin
                    e = eq.pop_front();
                    chk("error_cycle", cyc, e);
                end
            end
            if (active !== prev_act) begin
                if (aq.size() == 0) begin
                    chk("active_unexpected", active, prev_act);
                end else begin
                    a = aq.pop_front();
                    chk("active_cycle", cyc, a.cyc);
                    chk("active_level", active, a.lvl);
                end
                prev_act = active;
            end
        end
    end

    initial begin
        #1;
        do_reset(1'b0);

        // Four commas then a data byte.
        repeat (4) push_byte(COMMA);
        push_byte(8'h5A);
        push_byte(8'h00);
        run_scen();
        do_reset(1'b1);

        // Misaligned start: three junk bits.
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
        repeat (4) push_byte(COMMA);
        push_byte(8'hA5);
        push_byte(8'h00);
        run_scen();
        do_reset(1'b1);

        // Sync failure.
        push_byte(COMMA); push_byte(COMMA); push_byte(8'h00);
        push_byte(8'h00);
        run_scen();
        do_reset(1'b1);

        // Data separated by idle commas.
        repeat (4) push_byte(COMMA);
        push_byte(8'h11); push_byte(COMMA); push_byte(COMMA); push_byte(8'h22);
        push_byte(COMMA);
        run_scen();
        do_reset(1'b1);

        // Reset in the middle of a data byte, then recovery.
        repeat (4) push_byte(COMMA);
        for (int k = 7; k >= 3; k--) begin
            logic [7:0] b;
            b = 8'h33;
            stim.push_back(b[k]);
        end
        run_scen();
        do_reset(1'b1);
        repeat (4) push_byte(COMMA);
        push_byte(8'h33);
        push_byte(COMMA);
        run_scen();
        do_reset(1'b1);

        // Long run of data characters (loss-of-sync behaviour if enabled).
        repeat (4) push_byte(COMMA);
        repeat (LOS_LIMIT) push_byte(8'h55);
        push_byte(8'h00);
        run_scen();
        do_reset(1'b1);

        // Randomized streams.
        for (int s = 0; s < 10; s++) begin
            int nj;
            int nc;
            nj = $urandom_range(0, 7);
            for (int j = 0; j < nj; j++) stim.push_back(1'($urandom_range(0, 1)));
            nc = ($urandom_range(0, 3) == 0) ? 2 : 4;
            repeat (nc) push_byte(COMMA);
            repeat (14) begin
                if ($urandom_range(0, 2) == 0) push_byte(COMMA);
                else push_byte(8'($urandom_range(0, 255)));
            end
            push_byte(8'h00);
            run_scen();
            do_reset(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
